// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: turns a count/word-pairs/checksum byte
// stream into single-cycle instruction-store writes while holding the CPU in reset.
module imem_program_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [ADDR_W-1:0] IMemAddr,
  output logic [DATA_W-1:0] IMemData,
  output logic              IMemWrite,
  output logic              CpuHold,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   WordsLoaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int unsigned   DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q;
  logic [ADDR_W:0]     words_loaded;
  logic [ADDR_W:0]     wl_next;
  logic [7:0]          hi_q;
  logic [7:0]          acc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W:0]     count_n;
  logic                count_bad;
  logic                accept;
  logic                start_load;

  assign accept     = InValid && InReady;
  assign wl_next    = words_loaded + (ADDR_W+1)'(1);
  assign start_load = Start && (state_q == S_IDLE || state_q == S_DONE ||
                                state_q == S_ERROR);

  // A count byte of zero means a full store; anything above capacity is refused.
  always_comb begin
    count_n   = DEPTH_W;
    count_bad = 1'b0;
    if (InData != 8'd0) begin
      count_n   = (ADDR_W+1)'(InData);
      count_bad = 32'(InData) > DEPTH;
    end
  end

  // State register; reset has priority over everything, including Start.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output and next-state gets a default before the case so no
    // path through the block leaves a value unassigned and infers a latch.
    state_d   = state_q;
    InReady   = 1'b0;
    IMemWrite = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    CpuHold   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_COUNT;
      end
      S_COUNT: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (accept) state_d = count_bad ? S_ERROR : S_HI;
      end
      S_HI: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (accept) state_d = S_LO;
      end
      S_LO: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (accept) state_d = S_WRITE;
      end
      S_WRITE: begin
        IMemWrite = 1'b1;
        Busy      = 1'b1;
        state_d   = (wl_next == n_q) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (accept) state_d = (InData == acc_q) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        Done    = 1'b1;
        CpuHold = 1'b0;
        if (Start) state_d = S_COUNT;
      end
      S_ERROR: begin
        Error = 1'b1;
        if (Start) state_d = S_COUNT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write address/data are captured with the low byte so they are stable for
  // the whole WRITE cycle and hold afterwards; only IMemWrite qualifies them.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      n_q          <= '0;
      words_loaded <= '0;
      hi_q         <= '0;
      acc_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      if (start_load) begin
        words_loaded <= '0;
        acc_q        <= '0;
      end
      case (state_q)
        S_COUNT: if (accept) n_q <= count_n;
        S_HI: if (accept) begin
          hi_q  <= InData;
          acc_q <= acc_q ^ InData;
        end
        S_LO: if (accept) begin
          addr_q <= words_loaded[ADDR_W-1:0];
          data_q <= DATA_W'({hi_q, InData});
          acc_q  <= acc_q ^ InData;
        end
        S_WRITE: words_loaded <= wl_next;
        default: ;
      endcase
    end
  end

  assign IMemAddr    = addr_q;
  assign IMemData    = data_q;
  assign WordsLoaded = words_loaded;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed self-checking bench for imem_program_loader: good/bad checksum loads,
// full 128-word load, oversize count, throttled stream and mid-load reset.
module tb_imem_program_loader;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  InData;
  logic        InValid;
  logic        InReady;
  logic [6:0]  IMemAddr;
  logic [15:0] IMemData;
  logic        IMemWrite;
  logic        CpuHold;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [7:0]  WordsLoaded;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [6:0]  wa_q[$];
  logic [15:0] wd_q[$];

  imem_program_loader #(.ADDR_W(7), .DATA_W(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .InData      (InData),
    .InValid     (InValid),
    .InReady     (InReady),
    .IMemAddr    (IMemAddr),
    .IMemData    (IMemData),
    .IMemWrite   (IMemWrite),
    .CpuHold     (CpuHold),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error),
    .WordsLoaded (WordsLoaded)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Write log sampled mid-cycle; a strobe lasts exactly one cycle.
  always @(negedge Clk) begin
    if (IMemWrite === 1'b1) begin
      wa_q.push_back(IMemAddr);
      wd_q.push_back(IMemData);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int cyc = 0;
    InData  = b;
    InValid = 1'b1;
    while (InReady !== 1'b1 && cyc < 50) begin
      @(negedge Clk);
      cyc++;
    end
    check("accept_ready", InReady, 1);
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic bubble(input bit gap);
    if (gap) @(negedge Clk);
  endtask

  // Two-word stream 02,12,34,AB,CD,chk with write-latency checks.
  task automatic run_two(input string tag, input logic [7:0] chk, input bit gap);
    clear_log();
    pulse_start();
    send_byte(8'h02); bubble(gap);
    send_byte(8'h12); bubble(gap);
    send_byte(8'h34);
    check({tag, "_w0_strobe"}, IMemWrite, 1);
    check({tag, "_w0_addr"},   IMemAddr, 0);
    check({tag, "_w0_data"},   IMemData, 16'h1234);
    bubble(gap);
    send_byte(8'hAB); bubble(gap);
    send_byte(8'hCD);
    check({tag, "_w1_strobe"}, IMemWrite, 1);
    check({tag, "_w1_addr"},   IMemAddr, 1);
    check({tag, "_w1_data"},   IMemData, 16'hABCD);
    bubble(gap);
    send_byte(chk);
    check({tag, "_nwrites"}, wa_q.size(), 2);
    if (wa_q.size() >= 2) begin
      check({tag, "_log0"}, {wa_q[0], wd_q[0]}, {7'd0, 16'h1234});
      check({tag, "_log1"}, {wa_q[1], wd_q[1]}, {7'd1, 16'hABCD});
    end
    check({tag, "_words"}, WordsLoaded, 2);
    check({tag, "_busy"},  Busy, 0);
  endtask

  initial begin
    Reset   = 1'b0;
    Start   = 1'b0;
    InValid = 1'b0;
    InData  = 8'h00;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    check("rst_hold",  CpuHold, 1);
    check("rst_ready", InReady, 0);
    check("rst_write", IMemWrite, 0);
    check("rst_done",  Done, 0);
    check("rst_error", Error, 0);
    check("rst_busy",  Busy, 0);
    check("rst_words", WordsLoaded, 0);

    // Good two-word load: checksum 12^34^AB^CD = 40.
    run_two("good", 8'h40, 1'b0);
    check("good_done",  Done, 1);
    check("good_error", Error, 0);
    check("good_hold",  CpuHold, 0);

    // DONE is sticky and refuses bytes.
    InData  = 8'h55;
    InValid = 1'b1;
    repeat (3) @(negedge Clk);
    check("done_ready",  InReady, 0);
    check("done_sticky", Done, 1);
    InValid = 1'b0;

    // Bad checksum: words still written, load flagged as error.
    run_two("badck", 8'h41, 1'b0);
    check("badck_error", Error, 1);
    check("badck_done",  Done, 0);
    check("badck_hold",  CpuHold, 1);

    // Full 128-word load via count 0; XOR of 0..127 is 0.
    clear_log();
    pulse_start();
    check("start_busy", Busy, 1);
    check("start_hold", CpuHold, 1);
    check("start_done_cleared", Done, 0);
    send_byte(8'h00);
    for (int i = 0; i < 128; i++) begin
      send_byte(8'h00);
      send_byte(8'(i));
    end
    send_byte(8'h00);
    begin
      int bad = 0;
      for (int i = 0; i < wa_q.size(); i++)
        if (wa_q[i] !== 7'(i) || wd_q[i] !== 16'(i)) bad++;
      check("full_mismatch", bad, 0);
    end
    check("full_nwrites", wa_q.size(), 128);
    check("full_last_addr", IMemAddr, 127);
    check("full_words", WordsLoaded, 128);
    check("full_done", Done, 1);
    check("full_hold", CpuHold, 0);

    // Oversize count refused without any write.
    clear_log();
    pulse_start();
    send_byte(8'h81);
    check("over_error",   Error, 1);
    check("over_busy",    Busy, 0);
    check("over_hold",    CpuHold, 1);
    check("over_nwrites", wa_q.size(), 0);
    check("over_words",   WordsLoaded, 0);

    // Recovery: one-word load 5A C3, checksum 99, with a Start mid-load ignored.
    clear_log();
    pulse_start();
    send_byte(8'h01);
    pulse_start();
    check("midstart_busy", Busy, 1);
    send_byte(8'h5A);
    send_byte(8'hC3);
    check("rec_w_data", IMemData, 16'h5AC3);
    send_byte(8'h99);
    check("rec_done",    Done, 1);
    check("rec_words",   WordsLoaded, 1);
    check("rec_nwrites", wa_q.size(), 1);

    // Throttled stream: same writes, only delayed.
    run_two("gap", 8'h40, 1'b1);
    check("gap_done", Done, 1);

    // Reset while in LO after three words.
    clear_log();
    pulse_start();
    send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    send_byte(8'h07);
    check("pre_rst_words", WordsLoaded, 3);
    check("pre_rst_ready", InReady, 1);
    InData  = 8'h08;
    InValid = 1'b1;
    Reset   = 1'b0;
    @(negedge Clk);
    check("mid_rst_ready", InReady, 0);
    check("mid_rst_busy",  Busy, 0);
    check("mid_rst_hold",  CpuHold, 1);
    check("mid_rst_words", WordsLoaded, 0);
    check("mid_rst_addr",  IMemAddr, 0);
    check("mid_rst_data",  IMemData, 0);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    InValid = 1'b0;
    check("post_rst_nwrites", wa_q.size(), 3);
    check("post_rst_busy",    Busy, 0);

    // Start coinciding with reset: reset wins.
    Reset = 1'b0;
    Start = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b0;
    check("rst_vs_start_busy",  Busy, 0);
    check("rst_vs_start_ready", InReady, 0);
    @(negedge Clk);
    check("rst_vs_start_idle", Busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction-memory interface: fills the 128 x 16 instruction store from a byte stream while the processor is held in reset.
- Stream format: count byte, then high/low byte pairs, then checksum byte.
- Sits between the host/debug byte link and the instruction memory write port; drives the processor's hold/reset.
- Processor fetch then reads the loaded words from PC address 0 upward.

Parameters:
- ADDR_W, 7, instruction address width; capacity is 2^ADDR_W words (matches the 7-bit PC).
- DATA_W, 16, instruction width; fixed at two bytes, high byte first.

Ports:
- Clk  input  1  processor clock, rising-edge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored otherwise.
- InData  input  8  stream byte.
- InValid  input  1  InData valid.
- InReady  output  1  loader accepts a byte; transfer occurs on an edge where InValid&&InReady.
- IMemAddr  output  ADDR_W  instruction memory write address.
- IMemData  output  DATA_W  instruction memory write data.
- IMemWrite  output  1  single-cycle write strobe.
- CpuHold  output  1  active-high; processor held in reset while 1.
- Busy  output  1  load in progress (COUNT..CHECK).
- Done  output  1  last load completed with a good checksum.
- Error  output  1  last load aborted (bad count or bad checksum).
- WordsLoaded  output  ADDR_W+1  words written in the current/last load.

Behaviour:
- Reset (Reset==0 at an edge), takes effect next edge and holds from any state, including mid-load:
  - state=IDLE; CpuHold=1; InReady=0; IMemWrite=0; Busy=0; Done=0; Error=0.
  - IMemAddr=0; IMemData=0; WordsLoaded=0; checksum accumulator=0.
  - A write in flight is dropped; no IMemWrite after reset.
- States: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR, Start=1:
  - go COUNT; CpuHold=1, Busy=1.
  - Clear Done, Error, WordsLoaded and XOR accumulator.
- COUNT: InReady=1. On accept, N = (InData==0) ? 2^ADDR_W : InData.
  - N > 2^ADDR_W (129..255 at default) -> ERROR; no memory writes.
  - Otherwise -> HI.
- HI: InReady=1; on accept latch high byte, XOR into accumulator -> LO.
- LO: InReady=1; on accept latch low byte, XOR into accumulator -> WRITE.
- WRITE: InReady=0 for exactly this one cycle.
  - IMemWrite=1; IMemAddr=WordsLoaded[ADDR_W-1:0]; IMemData={hi,lo}.
  - WordsLoaded increments at the end of the cycle.
  - If new WordsLoaded==N -> CHECK, else -> HI.
  - Write strobe is one cycle after the low byte is accepted.
- CHECK: InReady=1; on accept compare InData with the accumulator (data bytes only; count byte excluded).
  - Equal -> DONE: Done=1, CpuHold=0, Busy=0 from the next cycle.
  - Unequal -> ERROR: Error=1, CpuHold=1, Busy=0.
- DONE/ERROR are sticky until Start or Reset.
  - InReady=0 in IDLE, DONE and ERROR; bytes offered there are not consumed.
- Boundaries:
  - Addresses written are 0..N-1 with no wrap; a full 128-word load ends at address 127 and never writes address 0 twice.
  - Start while Busy is ignored; the load continues.
  - Start in the same cycle as Reset low: reset wins.
  - InValid low stalls indefinitely in any accepting state; there is no timeout.
- IMemAddr/IMemData hold their last values outside WRITE; only IMemWrite qualifies them.

Test Plan:
- Reset low one edge, then high -> CpuHold=1, InReady=0, IMemWrite=0, Done=0, Error=0, WordsLoaded=0.
- Start; stream 02,12,34,AB,CD,checksum 0x40 -> writes addr0=0x1234, addr1=0xABCD; each write 1 cycle after its low byte; Done=1, CpuHold=0; WordsLoaded=2.
- Same stream with checksum 0x41 -> both words written; Error=1, Done=0, CpuHold=1.
- Count 0x00, 256 bytes = incrementing words 0x0000..0x007F, correct checksum -> 128 writes to addr 0..127; WordsLoaded=128; Done=1.
- Count 0x81 -> ERROR next cycle with zero IMemWrite pulses; Start then a valid 1-word stream recovers to Done=1.
- InValid toggling 1/0 every cycle mid-stream -> identical writes, only delayed. Reset low while in LO after 3 words -> IDLE, CpuHold=1, no further IMemWrite.
